// File: rtl/counter_sequencer.sv
// Run controller for the 8-bit counter: prescaled enable pulses, terminal-count/repeat sequencing.
// Optional feature: define COUNTER_SEQ_AUTORELOAD_EN to restart finite runs automatically after DONE.
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8,
  parameter int REP_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic [WIDTH-1:0] TERM,
  input  logic [DIV_W-1:0] DIV,
  input  logic [REP_W-1:0] REPEAT,
  output logic             CLK_EN,
  output logic             CNT_CLR,
  output logic [WIDTH-1:0] COUT,
  output logic             BUSY,
  output logic             WRAP,
  output logic             DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   presc_q, presc_d, div_l_q, div_l_d;
  logic [WIDTH-1:0]   cout_q, cout_d, term_l_q, term_l_d;
  logic [REP_W-1:0]   pass_q, pass_d, rep_l_q, rep_l_d, pass_inc;
  logic               clk_en_q, clk_en_d, cnt_clr_q, cnt_clr_d;
  logic               wrap_q, wrap_d, done_q, done_d, busy_q, busy_d;
  logic               start_ok, load, active, tick, wrap_hit, last_wrap;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
  logic               reload_q, reload_d;
`endif

  // Shared run-step decode; a PAUSED cycle with PAUSE low steps exactly like RUN.
  always_comb begin
    start_ok  = (state_q == S_IDLE) && START && !STOP;
    active    = (state_q != S_IDLE) && !STOP && !PAUSE;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
    active    = active && !reload_q;
    load      = start_ok || (reload_q && !STOP);
`else
    load      = start_ok;
`endif
    tick      = active && (presc_q == div_l_q);
    wrap_hit  = tick && (cout_q == term_l_q);
    pass_inc  = pass_q + REP_W'(1);
    last_wrap = wrap_hit && (rep_l_q != '0) && (pass_inc == rep_l_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_RUN;
      S_RUN, S_PAUSED: begin
        if (STOP)           state_d = S_IDLE;
        else if (PAUSE)     state_d = S_PAUSED;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        else                state_d = S_RUN;
`else
        else if (last_wrap) state_d = S_IDLE;
        else                state_d = S_RUN;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d   = presc_q;
    pass_d    = pass_q;
    cout_d    = cout_q;
    term_l_d  = term_l_q;
    div_l_d   = div_l_q;
    rep_l_d   = rep_l_q;
    clk_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    wrap_d    = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_d != S_IDLE);
`ifdef COUNTER_SEQ_AUTORELOAD_EN
    reload_d  = last_wrap;
`endif
    if (load) begin
      term_l_d  = TERM;
      div_l_d   = DIV;
      rep_l_d   = REPEAT;
      presc_d   = '0;
      pass_d    = '0;
      cout_d    = '0;
      cnt_clr_d = 1'b1;
    end else if (active) begin
      if (!tick) begin
        presc_d = presc_q + DIV_W'(1);
      end else begin
        presc_d  = '0;
        clk_en_d = 1'b1;
        if (wrap_hit) begin
          cout_d = '0;
          wrap_d = 1'b1;
          done_d = last_wrap;
          if (pass_q != '1) pass_d = pass_inc;
        end else begin
          cout_d = cout_q + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q   <= '0;
      pass_q    <= '0;
      cout_q    <= '0;
      term_l_q  <= '0;
      div_l_q   <= '0;
      rep_l_q   <= '0;
      clk_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
      reload_q  <= 1'b0;
`endif
    end else begin
      presc_q   <= presc_d;
      pass_q    <= pass_d;
      cout_q    <= cout_d;
      term_l_q  <= term_l_d;
      div_l_q   <= div_l_d;
      rep_l_q   <= rep_l_d;
      clk_en_q  <= clk_en_d;
      cnt_clr_q <= cnt_clr_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign CLK_EN  = clk_en_q;
  assign CNT_CLR = cnt_clr_q;
  assign COUT    = cout_q;
  assign BUSY    = busy_q;
  assign WRAP    = wrap_q;
  assign DONE    = done_q;

endmodule
